// File: rtl/calculator_fsm_param.sv
// Keypad calculator controller: chained add/sub/mult/div with an iterative restoring divider and circular result history.
// Non-divide keys act on the strobe edge (display valid next cycle); a divide holds busy for WIDTH cycles and drops strobes meanwhile.
module calculator_fsm_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [3:0]                 in,
    output logic [WIDTH-1:0]           display,
    output logic                       busy,
    output logic                       error,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] stack_count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int DCW  = $clog2(WIDTH);

    localparam logic [1:0] S_ENTRY  = 2'd0;
    localparam logic [1:0] S_OPWAIT = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_MUL = 4'hC;
    localparam logic [3:0] K_EQ  = 4'hD;
    localparam logic [3:0] K_DIV = 4'hF;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_entry;
    logic [2:0]       r_pending;
    logic             r_fresh;
    logic             r_error;
    logic             r_overflow;
    logic [WIDTH-1:0] r_hold;

    logic [WIDTH-1:0] r_div_rem;
    logic [WIDTH-1:0] r_div_quo;
    logic [WIDTH-1:0] r_div_dvs;
    logic [DCW-1:0]   r_div_cnt;
    logic             r_div_eq;
    logic [2:0]       r_div_op;

    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [CNTW-1:0]  r_count;
    logic [AW-1:0]    r_rec_off;
    logic             r_last_e;

    logic             w_key;
    logic             w_is_digit;
    logic             w_is_op;
    logic [2:0]       w_op;
    logic             w_div_start;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic [WIDTH+3:0] w_append;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_div_done;
    logic             w_rec_wrap;
    logic [AW-1:0]    w_rec_off_next;
    logic [AW-1:0]    w_rec_idx;
    logic [WIDTH-1:0] w_rec_dat;
    logic             w_push;
    logic [WIDTH-1:0] w_push_dat;

    assign w_key      = enable && (r_state != S_DIV);
    assign w_is_digit = (in <= 4'd9);

    always_comb begin
        w_op = OP_NONE;
        case (in)
            K_ADD:   w_op = OP_ADD;
            K_SUB:   w_op = OP_SUB;
            K_MUL:   w_op = OP_MUL;
            K_DIV:   w_op = OP_DIV;
            default: w_op = OP_NONE;
        endcase
    end

    assign w_is_op     = (w_op != OP_NONE);
    // Only an ENTRY-state evaluation with DIV pending needs the divider; OPWAIT never evaluates.
    assign w_div_start = w_key && (r_state == S_ENTRY) && (r_pending == OP_DIV) && (w_is_op || in == K_EQ);

    // With nothing pending the "result" is simply the entry register.
    always_comb begin
        w_sum     = {1'b0, r_acc} + {1'b0, r_entry};
        w_prod    = {{WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, r_entry};
        w_alu_res = r_entry;
        w_alu_ovf = 1'b0;
        case (r_pending)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_ovf = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_res = r_acc - r_entry;
                w_alu_ovf = (r_acc < r_entry);
            end
            OP_MUL: begin
                w_alu_res = w_prod[WIDTH-1:0];
                w_alu_ovf = |w_prod[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    assign w_append = {4'b0, r_entry} * (WIDTH+4)'(10) + (WIDTH+4)'(in);

    // Restoring division: dividend bits shift out of the quotient register into the remainder.
    assign w_div_shift = {r_div_rem, r_div_quo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_div_dvs});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_div_dvs;
    assign w_rem_next  = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
    assign w_quo_next  = {r_div_quo[WIDTH-2:0], w_div_ge};
    assign w_div_done  = (r_state == S_DIV) && (r_div_cnt == DCW'(WIDTH - 1));

    assign w_rec_wrap     = ((CNTW'(r_rec_off) + CNTW'(1)) == r_count);
    assign w_rec_off_next = (!r_last_e || w_rec_wrap) ? '0 : r_rec_off + AW'(1);
    assign w_rec_idx      = r_wr_ptr - AW'(1) - w_rec_off_next;
    assign w_rec_dat      = r_stack[w_rec_idx];

    always_comb begin
        w_push     = 1'b0;
        w_push_dat = w_alu_res;
        if (w_div_done && r_div_eq) begin
            w_push     = 1'b1;
            w_push_dat = w_quo_next;
        end else if (w_key && in == K_EQ) begin
            if (r_state == S_OPWAIT) begin
                w_push     = 1'b1;
                w_push_dat = r_acc;
            end else if (r_state == S_ENTRY && r_pending != OP_DIV) begin
                w_push     = 1'b1;
                w_push_dat = w_alu_res;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[r_wr_ptr] <= w_push_dat;
            r_wr_ptr          <= r_wr_ptr + AW'(1);
            if (r_count != CNTW'(DEPTH)) begin
                r_count <= r_count + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_ENTRY;
            r_acc      <= '0;
            r_entry    <= '0;
            r_pending  <= OP_NONE;
            r_fresh    <= 1'b1;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
            r_hold     <= '0;
            r_div_rem  <= '0;
            r_div_quo  <= '0;
            r_div_dvs  <= '0;
            r_div_cnt  <= '0;
            r_div_eq   <= 1'b0;
            r_div_op   <= OP_NONE;
            r_rec_off  <= '0;
            r_last_e   <= 1'b0;
        end else if (r_state == S_DIV) begin
            r_div_rem <= w_rem_next;
            r_div_quo <= w_quo_next;
            r_div_cnt <= r_div_cnt + DCW'(1);
            if (w_div_done) begin
                r_overflow <= 1'b0;
                if (r_div_eq) begin
                    r_entry   <= w_quo_next;
                    r_pending <= OP_NONE;
                    r_fresh   <= 1'b1;
                    r_state   <= S_ENTRY;
                end else begin
                    r_acc     <= w_quo_next;
                    r_pending <= r_div_op;
                    r_state   <= S_OPWAIT;
                end
            end
        end else if (w_key) begin
            r_last_e <= (in == 4'hE);
            if (w_div_start) begin
                if (r_entry == '0) begin
                    r_state   <= S_ERR;
                    r_error   <= 1'b1;
                    r_acc     <= '0;
                    r_entry   <= '0;
                    r_pending <= OP_NONE;
                end else begin
                    r_state   <= S_DIV;
                    r_hold    <= display;
                    r_div_rem <= '0;
                    r_div_quo <= r_acc;
                    r_div_dvs <= r_entry;
                    r_div_cnt <= '0;
                    r_div_eq  <= (in == K_EQ);
                    r_div_op  <= w_op;
                end
            end else begin
                case (r_state)
                    S_ENTRY, S_OPWAIT: begin
                        if (w_is_digit) begin
                            if (r_state == S_ENTRY && !r_fresh) begin
                                r_entry    <= w_append[WIDTH-1:0];
                                r_overflow <= |w_append[WIDTH+3:WIDTH];
                            end else begin
                                r_entry <= WIDTH'(in);
                                r_fresh <= 1'b0;
                                r_state <= S_ENTRY;
                            end
                        end else if (w_is_op) begin
                            if (r_state == S_ENTRY) begin
                                r_acc <= w_alu_res;
                                if (r_pending != OP_NONE) begin
                                    r_overflow <= w_alu_ovf;
                                end
                            end
                            r_pending <= w_op;
                            r_state   <= S_OPWAIT;
                        end else if (in == K_EQ) begin
                            if (r_state == S_ENTRY) begin
                                r_entry <= w_alu_res;
                                if (r_pending != OP_NONE) begin
                                    r_overflow <= w_alu_ovf;
                                end
                            end else begin
                                r_entry <= r_acc;
                            end
                            r_pending <= OP_NONE;
                            r_fresh   <= 1'b1;
                            r_state   <= S_ENTRY;
                        end else if (r_count != '0) begin
                            r_entry   <= w_rec_dat;
                            r_rec_off <= w_rec_off_next;
                            r_fresh   <= 1'b1;
                            r_state   <= S_ENTRY;
                        end
                    end
                    S_ERR: begin
                        if (w_is_digit) begin
                            r_error   <= 1'b0;
                            r_acc     <= '0;
                            r_entry   <= WIDTH'(in);
                            r_pending <= OP_NONE;
                            r_fresh   <= 1'b0;
                            r_state   <= S_ENTRY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (r_state)
            S_ENTRY:  display = r_entry;
            S_OPWAIT: display = r_acc;
            S_DIV:    display = r_hold;
            default:  display = '0;
        endcase
    end

    assign busy        = (r_state == S_DIV);
    assign error       = r_error;
    assign overflow    = r_overflow;
    assign stack_count = r_count;

endmodule

// File: tb/tb_calculator_fsm_param.sv
// Directed bench for calculator_fsm_param (WIDTH=32, DEPTH=8) with hand-computed expectations.
module tb_calculator_fsm_param;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       enable;
    logic [3:0]                 in;
    logic [WIDTH-1:0]           display;
    logic                       busy;
    logic                       error;
    logic                       overflow;
    logic [$clog2(DEPTH+1)-1:0] stack_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    calculator_fsm_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .in          (in),
        .display     (display),
        .busy        (busy),
        .error       (error),
        .overflow    (overflow),
        .stack_count (stack_count)
    );

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        in     = 4'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic press(input logic [3:0] k);
        enable = 1'b1;
        in     = k;
        @(negedge clock);
        enable = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (display !== '0) begin n_bad++; $display("FAIL reset_display got %0d want 0", display); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want 0", error); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_cmp++; if (stack_count !== 4'd0) begin n_bad++; $display("FAIL reset_stack_count got %0d want 0", stack_count); end
    endtask

    task automatic test_add_chain();
        logic [3:0]  keys [6];
        int unsigned exp  [6];
        keys = '{4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'hD};
        exp  = '{1, 12, 12, 3, 34, 46};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            press(keys[i]);
            n_cmp++;
            if (display !== WIDTH'(exp[i])) begin
                n_bad++; $display("FAIL add_chain_step%0d got %0d want %0d", i, display, exp[i]);
            end
        end
        n_cmp++; if (stack_count !== 4'd1) begin n_bad++; $display("FAIL add_chain_stack_count got %0d want 1", stack_count); end
    endtask

    task automatic test_mul_sub();
        logic [3:0]  keys [6];
        int unsigned exp  [6];
        keys = '{4'h7, 4'hC, 4'h6, 4'hB, 4'h2, 4'hD};
        exp  = '{7, 7, 6, 42, 2, 40};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            press(keys[i]);
            n_cmp++;
            if (display !== WIDTH'(exp[i])) begin
                n_bad++; $display("FAIL mul_sub_step%0d got %0d want %0d", i, display, exp[i]);
            end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mul_sub_overflow got %b want 0", overflow); end
    endtask

    task automatic test_divide();
        int busy_cycles = 0;
        do_reset();
        press(4'h1); press(4'h0); press(4'h0); press(4'hF); press(4'h7);
        n_cmp++; if (display !== 32'd7) begin n_bad++; $display("FAIL div_divisor_display got %0d want 7", display); end
        enable = 1'b1;
        in     = 4'hD;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            enable = 1'b0;
            if (!busy) break;
            busy_cycles++;
            // Strobes mid-divide and on the edge that drops busy must both be lost.
            if (busy_cycles == 10 || busy_cycles == WIDTH) begin
                enable = 1'b1;
                in     = 4'h5;
            end
        end
        enable = 1'b0;
        n_cmp++; if (busy_cycles != WIDTH) begin n_bad++; $display("FAIL div_busy_cycles got %0d want %0d", busy_cycles, WIDTH); end
        n_cmp++; if (display !== 32'd14) begin n_bad++; $display("FAIL div_result got %0d want 14", display); end
        n_cmp++; if (stack_count !== 4'd1) begin n_bad++; $display("FAIL div_stack_count got %0d want 1", stack_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL div_busy_after got %b want 0", busy); end
    endtask

    task automatic test_div_zero();
        do_reset();
        press(4'h5); press(4'hF); press(4'h0); press(4'hD);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL divzero_error got %b want 1", error); end
        n_cmp++; if (display !== '0) begin n_bad++; $display("FAIL divzero_display got %0d want 0", display); end
        n_cmp++; if (stack_count !== 4'd0) begin n_bad++; $display("FAIL divzero_no_push got %0d want 0", stack_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL divzero_busy got %b want 0", busy); end
        press(4'h3);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL divzero_clear_error got %b want 0", error); end
        n_cmp++; if (display !== 32'd3) begin n_bad++; $display("FAIL divzero_digit got %0d want 3", display); end
    endtask

    task automatic test_reset_in_div();
        do_reset();
        press(4'h9); press(4'hF); press(4'h2);
        press(4'hD);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_div_busy_rise got %b want 1", busy); end
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_div_async_busy got %b want 0", busy); end
        n_cmp++; if (display !== '0) begin n_bad++; $display("FAIL rst_div_async_display got %0d want 0", display); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_div_busy_next got %b want 0", busy); end
        n_cmp++; if (display !== '0) begin n_bad++; $display("FAIL rst_div_display_next got %0d want 0", display); end
    endtask

    task automatic test_overflow();
        logic [3:0] digits [10];
        digits = '{4'h4, 4'h2, 4'h9, 4'h4, 4'h9, 4'h6, 4'h7, 4'h2, 4'h9, 4'h5};
        do_reset();
        for (int i = 0; i < 10; i++) press(digits[i]);
        n_cmp++; if (display !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL ovf_max_entry got %0d want 4294967295", display); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_max_entry_flag got %b want 0", overflow); end
        press(4'hA); press(4'h1); press(4'hD);
        n_cmp++; if (display !== '0) begin n_bad++; $display("FAIL ovf_add_wrap got %0d want 0", display); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_add_carry got %b want 1", overflow); end
        press(4'h2); press(4'hA); press(4'h2); press(4'hD);
        n_cmp++; if (display !== 32'd4) begin n_bad++; $display("FAIL ovf_then_add got %0d want 4", display); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_then_clear got %b want 0", overflow); end
        press(4'h1); press(4'hB); press(4'h2); press(4'hD);
        n_cmp++; if (display !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL ovf_sub_wrap got %0d want 4294967295", display); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sub_borrow got %b want 1", overflow); end
        do_reset();
        for (int i = 0; i < 10; i++) press(digits[i]);
        press(4'h0);
        n_cmp++; if (display !== 32'hFFFF_FFF6) begin n_bad++; $display("FAIL ovf_append_wrap got %0d want 4294967286", display); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_append_flag got %b want 1", overflow); end
    endtask

    task automatic test_opwait();
        do_reset();
        press(4'h8); press(4'hA);
        press(4'hB);
        n_cmp++; if (display !== 32'd8) begin n_bad++; $display("FAIL opwait_replace_display got %0d want 8", display); end
        press(4'h3); press(4'hD);
        n_cmp++; if (display !== 32'd5) begin n_bad++; $display("FAIL opwait_replace_result got %0d want 5", display); end
        do_reset();
        press(4'h6); press(4'hE);
        n_cmp++; if (display !== 32'd6) begin n_bad++; $display("FAIL recall_empty got %0d want 6", display); end
    endtask

    task automatic test_stack();
        int unsigned exp_rcl [9];
        exp_rcl = '{9, 8, 7, 6, 5, 4, 3, 2, 9};
        do_reset();
        for (int v = 1; v <= 9; v++) begin
            press(4'(v));
            press(4'hD);
            n_cmp++;
            if (display !== WIDTH'(v)) begin n_bad++; $display("FAIL stack_push%0d got %0d want %0d", v, display, v); end
        end
        n_cmp++; if (stack_count !== 4'd8) begin n_bad++; $display("FAIL stack_count_sat got %0d want 8", stack_count); end
        for (int i = 0; i < 9; i++) begin
            press(4'hE);
            n_cmp++;
            if (display !== WIDTH'(exp_rcl[i])) begin
                n_bad++; $display("FAIL stack_recall%0d got %0d want %0d", i, display, exp_rcl[i]);
            end
        end
        press(4'h1);
        press(4'hE);
        n_cmp++; if (display !== 32'd9) begin n_bad++; $display("FAIL stack_recall_restart got %0d want 9", display); end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        in     = 4'h0;
        test_reset();
        test_add_chain();
        test_mul_sub();
        test_divide();
        test_div_zero();
        test_reset_in_div();
        test_overflow();
        test_opwait();
        test_stack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
